// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared types, widths and helpers for the DDR round-robin arbiter
//
// Purpose: arbiter FSM state encoding, Avalon-MM DDR port widths, default
//          channel count and the read-burst clamp helper.
// Ports:   none (package)
package ddr_arb_pkg;

  localparam int DDR_AW       = 29;   // 64-bit word address
  localparam int DDR_DW       = 64;
  localparam int DDR_BEW      = 8;
  localparam int BURST_W      = 8;
  localparam int DEF_NCH      = 3;
  localparam int DEF_MAXBURST = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

  // A zero burst still moves one beat; anything above maxb is cut to maxb.
  function automatic logic [BURST_W-1:0] clamp_burst(input logic [BURST_W-1:0] b,
                                                     input int                  maxb);
    if (b == '0)
      return BURST_W'(1);
    if (int'(b) > maxb)
      return BURST_W'(maxb);
    return b;
  endfunction

endpackage

// File: rtl/ddr_rr_pick.sv
// rtl/ddr_rr_pick.sv - combinational rotate-and-priority-encode grant picker
//
// Purpose: return the first pending channel found when searching upward
//          from (i_last+1) mod NCH, wrapping around to i_last itself.
// Ports:
//   i_pending  in  NCH  channels with an outstanding request
//   i_last     in  LW   index of the most recent grant
//   o_grant    out LW   selected channel (0 when none pending)
//   o_valid    out 1    at least one channel pending
module ddr_rr_pick #(
  parameter int NCH = 3,
  parameter int LW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] i_pending,
  input  logic [LW-1:0]  i_last,
  output logic [LW-1:0]  o_grant,
  output logic           o_valid
);

  logic [LW-1:0] w_idx;

  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    w_idx   = '0;
    // i runs 1..NCH so the last grant is considered last of all.
    for (int i = 1; i <= NCH; i++) begin
      w_idx = LW'((int'(i_last) + i) % NCH);
      if (!o_valid && i_pending[w_idx]) begin
        o_valid = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/ddr_rr_arb.sv
// rtl/ddr_rr_arb.sv - round-robin arbiter sharing one Avalon-MM DDR port
//
// Purpose: serve NCH toggle-handshake clients (read bursts, single-beat
//          masked writes) over one 64-bit DDR port, one command at a time.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ram_waitrequest                 in   Avalon stall
//   ram_read/ram_write              out  command, held until accepted
//   ram_burstcnt/addr/writedata/byteenable  out  registered command fields
//   ram_readdata/ram_read_ready     in   read beat return
//   ch_addr/burst/we/wdata/be       in   packed per-channel request fields
//   ch_req/ch_ack                   toggle handshake (pending when different)
//   ch_data/ch_ready                out  registered read beat + owner strobe
module ddr_rr_arb
  import ddr_arb_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int MAXBURST = DEF_MAXBURST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ram_waitrequest,
  output logic [BURST_W-1:0]     ram_burstcnt,
  output logic [DDR_AW-1:0]      ram_addr,
  output logic                   ram_read,
  output logic                   ram_write,
  output logic [DDR_DW-1:0]      ram_writedata,
  output logic [DDR_BEW-1:0]     ram_byteenable,
  input  logic [DDR_DW-1:0]      ram_readdata,
  input  logic                   ram_read_ready,
  input  logic [NCH*DDR_AW-1:0]  ch_addr,
  input  logic [NCH*BURST_W-1:0] ch_burst,
  input  logic [NCH-1:0]         ch_we,
  input  logic [NCH*DDR_DW-1:0]  ch_wdata,
  input  logic [NCH*DDR_BEW-1:0] ch_be,
  input  logic [NCH-1:0]         ch_req,
  output logic [NCH-1:0]         ch_ack,
  output logic [DDR_DW-1:0]      ch_data,
  output logic [NCH-1:0]         ch_ready
);

  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_t         r_state,    w_state_nxt;
  logic [LW-1:0]      r_last,     w_last_nxt;
  logic [LW-1:0]      r_grant,    w_grant_nxt;
  logic               r_read,     w_read_nxt;
  logic               r_write,    w_write_nxt;
  logic [BURST_W-1:0] r_burstcnt, w_burstcnt_nxt;
  logic [BURST_W-1:0] r_cnt,      w_cnt_nxt;
  logic [DDR_AW-1:0]  r_addr,     w_addr_nxt;
  logic [DDR_DW-1:0]  r_wdata,    w_wdata_nxt;
  logic [DDR_BEW-1:0] r_be,       w_be_nxt;
  logic [NCH-1:0]     r_ack,      w_ack_nxt;
  logic [DDR_DW-1:0]  r_data,     w_data_nxt;
  logic [NCH-1:0]     r_ready,    w_ready_nxt;

  logic [NCH-1:0]     w_pending;
  logic [LW-1:0]      w_pick;
  logic               w_pick_valid;

  logic [DDR_AW-1:0]  w_addr_arr  [NCH];
  logic [BURST_W-1:0] w_burst_arr [NCH];
  logic [DDR_DW-1:0]  w_wdata_arr [NCH];
  logic [DDR_BEW-1:0] w_be_arr    [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign w_addr_arr[g]  = ch_addr[g*DDR_AW +: DDR_AW];
    assign w_burst_arr[g] = ch_burst[g*BURST_W +: BURST_W];
    assign w_wdata_arr[g] = ch_wdata[g*DDR_DW +: DDR_DW];
    assign w_be_arr[g]    = ch_be[g*DDR_BEW +: DDR_BEW];
  end

  // Comparing against our own ack keeps the channel in service invisible
  // until its ack toggles, even if the client has already re-toggled req.
  assign w_pending = ch_req ^ r_ack;

  ddr_rr_pick #(
    .NCH (NCH),
    .LW  (LW)
  ) u_pick (
    .i_pending (w_pending),
    .i_last    (r_last),
    .o_grant   (w_pick),
    .o_valid   (w_pick_valid)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_grant_nxt    = r_grant;
    w_read_nxt     = r_read;
    w_write_nxt    = r_write;
    w_burstcnt_nxt = r_burstcnt;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_be_nxt       = r_be;
    w_ack_nxt      = r_ack;
    w_data_nxt     = r_data;
    w_ready_nxt    = '0;

    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick;
          w_last_nxt  = w_pick;
          w_addr_nxt  = w_addr_arr[w_pick];
          w_wdata_nxt = w_wdata_arr[w_pick];
          if (ch_we[w_pick]) begin
            w_write_nxt    = 1'b1;
            w_burstcnt_nxt = BURST_W'(1);
            w_be_nxt       = w_be_arr[w_pick];
          end else begin
            w_read_nxt     = 1'b1;
            w_burstcnt_nxt = clamp_burst(w_burst_arr[w_pick], MAXBURST);
            w_be_nxt       = '1;
          end
          w_state_nxt = CMD;
        end
      end

      CMD: begin
        if (!ram_waitrequest) begin
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
          if (r_write) begin
            w_ack_nxt[r_grant] = ~r_ack[r_grant];
            w_state_nxt        = IDLE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = RDATA;
          end
        end
      end

      RDATA: begin
        if (ram_read_ready) begin
          w_data_nxt           = ram_readdata;
          w_ready_nxt[r_grant] = 1'b1;
          w_cnt_nxt            = r_cnt + BURST_W'(1);
          // Ack is registered with the same edge as the final ch_ready,
          // so the client sees both in the same cycle.
          if (r_cnt == r_burstcnt - BURST_W'(1)) begin
            w_ack_nxt[r_grant] = ~r_ack[r_grant];
            w_state_nxt        = IDLE;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= LW'(NCH - 1);
      r_grant    <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_burstcnt <= BURST_W'(1);
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '1;
      r_ack      <= '0;
      r_data     <= '0;
      r_ready    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_grant    <= w_grant_nxt;
      r_read     <= w_read_nxt;
      r_write    <= w_write_nxt;
      r_burstcnt <= w_burstcnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_be       <= w_be_nxt;
      r_ack      <= w_ack_nxt;
      r_data     <= w_data_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign ram_read       = r_read;
  assign ram_write      = r_write;
  assign ram_burstcnt   = r_burstcnt;
  assign ram_addr       = r_addr;
  assign ram_writedata  = r_wdata;
  assign ram_byteenable = r_be;
  assign ch_ack         = r_ack;
  assign ch_data        = r_data;
  assign ch_ready       = r_ready;

endmodule

// File: tb/tb_ddr_rr_arb.sv
// tb/tb_ddr_rr_arb.sv - directed scoreboard bench for ddr_rr_arb (NCH=3, MAXBURST=128)
module tb_ddr_rr_arb;

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_waitrequest;
  logic [7:0]    ram_burstcnt;
  logic [28:0]   ram_addr;
  logic          ram_read;
  logic          ram_write;
  logic [63:0]   ram_writedata;
  logic [7:0]    ram_byteenable;
  logic [63:0]   ram_readdata;
  logic          ram_read_ready;
  logic [86:0]   ch_addr;
  logic [23:0]   ch_burst;
  logic [2:0]    ch_we;
  logic [191:0]  ch_wdata;
  logic [23:0]   ch_be;
  logic [2:0]    ch_req;
  logic [2:0]    ch_ack;
  logic [63:0]   ch_data;
  logic [2:0]    ch_ready;

  logic [28:0]   a_addr  [3];
  logic [7:0]    a_burst [3];
  logic [63:0]   a_wdata [3];
  logic [7:0]    a_be    [3];
  logic [2:0]    req;

  assign ch_addr  = {a_addr[2], a_addr[1], a_addr[0]};
  assign ch_burst = {a_burst[2], a_burst[1], a_burst[0]};
  assign ch_wdata = {a_wdata[2], a_wdata[1], a_wdata[0]};
  assign ch_be    = {a_be[2], a_be[1], a_be[0]};
  assign ch_req   = req;

  typedef struct {
    logic [1:0]  ch;
    logic [63:0] data;
    bit          last;
    logic        ack;
  } beat_t;

  beat_t sbq[$];
  beat_t m_e;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  ddr_rr_arb dut (
    .clk             (clk),
    .reset           (reset),
    .ram_waitrequest (ram_waitrequest),
    .ram_burstcnt    (ram_burstcnt),
    .ram_addr        (ram_addr),
    .ram_read        (ram_read),
    .ram_write       (ram_write),
    .ram_writedata   (ram_writedata),
    .ram_byteenable  (ram_byteenable),
    .ram_readdata    (ram_readdata),
    .ram_read_ready  (ram_read_ready),
    .ch_addr         (ch_addr),
    .ch_burst        (ch_burst),
    .ch_we           (ch_we),
    .ch_wdata        (ch_wdata),
    .ch_be           (ch_be),
    .ch_req          (ch_req),
    .ch_ack          (ch_ack),
    .ch_data         (ch_data),
    .ch_ready        (ch_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_beats(input int b);
    if (b == 0) return 1;
    if (b > 128) return 128;
    return b;
  endfunction

  task automatic wait_cmd(output int lat);
    lat = 0;
    while (!(ram_read || ram_write) && lat < 40) begin
      step();
      lat++;
    end
    check("cmd_seen", 64'(ram_read | ram_write), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_read"},  ram_read, 0);
    check({tag, "_write"}, ram_write, 0);
    check({tag, "_bcnt"},  ram_burstcnt, 1);
    check({tag, "_addr"},  ram_addr, 0);
    check({tag, "_wdata"}, ram_writedata, 0);
    check({tag, "_be"},    ram_byteenable, 8'hFF);
    check({tag, "_ack"},   ch_ack, 0);
    check({tag, "_data"},  ch_data, 0);
    check({tag, "_ready"}, ch_ready, 0);
  endtask

  // Acts as the DDR side for one read: check the command, then return n beats.
  task automatic serve_read(input logic [1:0] ch, input logic [28:0] addr,
                            input int n, input bit gap, input bit chk_lat);
    int          lat;
    logic [63:0] d;
    beat_t       e;
    wait_cmd(lat);
    if (chk_lat) check("cmd_latency", lat, 1);
    check("rd_cmd",  ram_read, 1);
    check("rd_addr", ram_addr, addr);
    check("rd_bcnt", ram_burstcnt, n);
    check("rd_be",   ram_byteenable, 8'hFF);
    step();
    check("rd_drop", ram_read, 0);
    for (int k = 0; k < n; k++) begin
      if (gap && k > 0) begin
        ram_read_ready = 1'b0;
        step();
      end
      d = {$urandom, $urandom};
      ram_readdata   = d;
      ram_read_ready = 1'b1;
      e.ch   = ch;
      e.data = d;
      e.last = (k == n - 1);
      e.ack  = req[ch];
      sbq.push_back(e);
      step();
    end
    ram_read_ready = 1'b0;
    check("rd_ack", ch_ack[ch], req[ch]);
    @(negedge clk);
    #1;
    check("rd_sb_empty", sbq.size(), 0);
  endtask

  // Scoreboard consumer: every ch_ready pulse must match the next pushed beat.
  always @(negedge clk) begin
    if (ch_ready !== 3'b000) begin
      if (sbq.size() == 0) begin
        check("ready_unexpected", 64'(ch_ready), 64'd0);
      end else begin
        m_e = sbq.pop_front();
        check("ready_owner", ch_ready, 3'b001 << m_e.ch);
        check("ready_data",  ch_data, m_e.data);
        if (m_e.last) check("ack_with_last", ch_ack[m_e.ch], m_e.ack);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    beat_t e;
    reset           = 1'b1;
    req             = 3'b000;
    ch_we           = 3'b000;
    ram_waitrequest = 1'b0;
    ram_read_ready  = 1'b0;
    ram_readdata    = '0;
    for (int i = 0; i < 3; i++) begin
      a_addr[i]  = '0;
      a_burst[i] = 8'd1;
      a_wdata[i] = '0;
      a_be[i]    = 8'hFF;
    end
    step();
    step();
    check_reset_vals("rst");
    reset = 1'b0;
    step();
    check_reset_vals("idle");

    // Fairness: all three at once, then 0 and 2 again (pointer wraps).
    a_addr[0] = 29'h10;
    a_addr[1] = 29'h20;
    a_addr[2] = 29'h30;
    req = req ^ 3'b111;
    serve_read(2'd0, 29'h10, 1, 1'b0, 1'b1);
    serve_read(2'd1, 29'h20, 1, 1'b0, 1'b1);
    serve_read(2'd2, 29'h30, 1, 1'b0, 1'b1);
    req = req ^ 3'b101;
    serve_read(2'd0, 29'h10, 1, 1'b0, 1'b1);
    serve_read(2'd2, 29'h30, 1, 1'b0, 1'b1);

    // Single 4-beat read on ch0.
    a_addr[0]  = 29'h100;
    a_burst[0] = 8'd4;
    req[0]     = !req[0];
    serve_read(2'd0, 29'h100, 4, 1'b0, 1'b1);

    // Masked write on ch1 stalled for 5 cycles.
    a_addr[1]       = 29'h2A;
    a_wdata[1]      = 64'hDEADBEEF_01234567;
    a_be[1]         = 8'h0F;
    ch_we[1]        = 1'b1;
    ram_waitrequest = 1'b1;
    req[1]          = !req[1];
    wait_cmd(lat);
    check("wr_latency", lat, 1);
    for (int j = 0; j < 6; j++) begin
      if (j == 5) ram_waitrequest = 1'b0;
      check("wr_write", ram_write, 1);
      check("wr_read",  ram_read, 0);
      check("wr_addr",  ram_addr, 29'h2A);
      check("wr_wdata", ram_writedata, 64'hDEADBEEF_01234567);
      check("wr_be",    ram_byteenable, 8'h0F);
      check("wr_bcnt",  ram_burstcnt, 1);
      check("wr_ack_hold", ch_ack[1], !req[1]);
      step();
    end
    check("wr_drop",  ram_write, 0);
    check("wr_ack",   ch_ack[1], req[1]);
    check("wr_ready", ch_ready, 0);
    ch_we[1] = 1'b0;
    step();

    // Burst edge cases.
    a_addr[1]  = 29'h400;
    a_burst[1] = 8'd0;
    req[1]     = !req[1];
    serve_read(2'd1, 29'h400, exp_beats(0), 1'b0, 1'b1);
    a_addr[2]  = 29'h800;
    a_burst[2] = 8'd255;
    req[2]     = !req[2];
    serve_read(2'd2, 29'h800, exp_beats(255), 1'b0, 1'b1);

    // Gaps between beats of a 3-beat burst.
    a_addr[0]  = 29'h1234;
    a_burst[0] = 8'd3;
    req[0]     = !req[0];
    serve_read(2'd0, 29'h1234, 3, 1'b1, 1'b1);

    // Reset after beat 2 of an 8-beat burst.
    a_addr[1]  = 29'h1F00;
    a_burst[1] = 8'd8;
    req[1]     = !req[1];
    wait_cmd(lat);
    check("rm_cmd", ram_read, 1);
    step();
    for (int k = 0; k < 2; k++) begin
      ram_readdata   = {$urandom, $urandom};
      ram_read_ready = 1'b1;
      e.ch   = 2'd1;
      e.data = ram_readdata;
      e.last = 1'b0;
      e.ack  = req[1];
      sbq.push_back(e);
      step();
    end
    ram_read_ready = 1'b0;
    reset          = 1'b1;
    req            = 3'b000;
    step();
    check_reset_vals("rst_mid");
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ram_readdata   = {$urandom, $urandom};
      ram_read_ready = 1'b1;
      step();
    end
    ram_read_ready = 1'b0;
    step();
    step();
    check("rm_sb_empty", sbq.size(), 0);
    check("rm_idle_read", ram_read, 0);
    a_addr[2]  = 29'h2200;
    a_burst[2] = 8'd2;
    req[2]     = !req[2];
    serve_read(2'd2, 29'h2200, 2, 1'b0, 1'b1);

    step();
    check("final_sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
